// File: rtl/mac_result_checker.sv
// Streaming checker for FP32 MAC results: queues expected values, compares each
// DUT result in issue order with a magnitude tolerance, and keeps run statistics.
module mac_result_checker #(
    parameter int NUM_VECTORS = 1000,
    parameter int FIFO_DEPTH  = 8,
    parameter int TOL         = 0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic        exp_valid,
    input  logic [31:0] exp_mac,
    input  logic        res_valid,
    input  logic [31:0] res_mac,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic [15:0] first_fail_idx,
    output logic [31:0] first_fail_got,
    output logic [31:0] first_fail_exp,
    output logic        overflow,
    output logic        underflow
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [16:0] LP_NUM = 17'(NUM_VECTORS);
    localparam logic [30:0] LP_TOL = 31'(TOL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_busy;
    logic        r_done;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_cmp_valid;
    logic        r_cmp_pass;
    logic [31:0] r_cmp_got;
    logic [31:0] r_cmp_exp;
    logic [15:0] r_pass;
    logic [15:0] r_fail;
    logic        r_fail_seen;
    logic [15:0] r_ff_idx;
    logic [31:0] r_ff_got;
    logic [31:0] r_ff_exp;

    logic        w_active;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic [16:0] w_sum;
    logic [15:0] w_idx;

    // Sign must agree; magnitudes may differ by at most TOL (exact equality always passes).
    function automatic logic f_match(input logic [31:0] got, input logic [31:0] expv);
        logic [30:0] diff;
        if (got[30:0] >= expv[30:0]) begin
            diff = got[30:0] - expv[30:0];
        end else begin
            diff = expv[30:0] - got[30:0];
        end
        return (got == expv) || ((got[31] == expv[31]) && (diff <= LP_TOL));
    endfunction

    assign w_active = (r_state == ST_RUN) && !start;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = w_active && res_valid && !w_empty;
    assign w_push   = w_active && exp_valid && (!w_full || w_pop);
    assign w_sum    = {1'b0, r_pass} + {1'b0, r_fail};
    assign w_idx    = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    // Next-state logic; start from any state (re)enters RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_RUN;
                else       w_next = ST_IDLE;
            end
            ST_RUN: begin
                if (start)                 w_next = ST_RUN;
                else if (w_sum >= LP_NUM)  w_next = ST_DONE;
                else                       w_next = ST_RUN;
            end
            ST_DONE: begin
                if (start) w_next = ST_RUN;
                else       w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register with registered busy/done decodes.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_RUN);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Expected-value storage; contents are don't-care while pointers say empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= exp_mac;
    end

    // FIFO pointers and sticky protocol-error flags.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (start) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_active && exp_valid && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_active && res_valid && w_empty)          r_underflow <= 1'b1;
        end
    end

    // Single compare stage; a start pulse discards whatever is in flight.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_cmp_valid <= 1'b0;
            r_cmp_pass  <= 1'b0;
            r_cmp_got   <= 32'h0000_0000;
            r_cmp_exp   <= 32'h0000_0000;
        end else begin
            r_cmp_valid <= w_pop;
            r_cmp_pass  <= f_match(res_mac, r_mem[r_rd_ptr[AW-1:0]]);
            r_cmp_got   <= res_mac;
            r_cmp_exp   <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    // Saturating statistics and first-failure capture.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_pass      <= 16'h0000;
            r_fail      <= 16'h0000;
            r_fail_seen <= 1'b0;
            r_ff_idx    <= 16'hFFFF;
            r_ff_got    <= 32'h0000_0000;
            r_ff_exp    <= 32'h0000_0000;
        end else if (start) begin
            r_pass      <= 16'h0000;
            r_fail      <= 16'h0000;
            r_fail_seen <= 1'b0;
            r_ff_idx    <= 16'hFFFF;
            r_ff_got    <= 32'h0000_0000;
            r_ff_exp    <= 32'h0000_0000;
        end else if (r_cmp_valid) begin
            if (r_cmp_pass) begin
                if (r_pass != 16'hFFFF) r_pass <= r_pass + 16'd1;
            end else begin
                if (r_fail != 16'hFFFF) r_fail <= r_fail + 16'd1;
                if (!r_fail_seen) begin
                    r_fail_seen <= 1'b1;
                    r_ff_idx    <= w_idx;
                    r_ff_got    <= r_cmp_got;
                    r_ff_exp    <= r_cmp_exp;
                end
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass_count     = r_pass;
    assign fail_count     = r_fail;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_got = r_ff_got;
    assign first_fail_exp = r_ff_exp;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule

// File: tb/tb_mac_result_checker.sv
// Directed bench for mac_result_checker: two instances (TOL=0 and TOL=1) share stimulus.
module tb_mac_result_checker;

    logic        clk;
    logic        RST;
    logic        start;
    logic        exp_valid;
    logic [31:0] exp_mac;
    logic        res_valid;
    logic [31:0] res_mac;

    logic        d0_busy, d0_done, d0_ov, d0_un;
    logic [15:0] d0_pass, d0_fail, d0_idx;
    logic [31:0] d0_got, d0_exp;
    logic        d1_busy, d1_done, d1_ov, d1_un;
    logic [15:0] d1_pass, d1_fail, d1_idx;
    logic [31:0] d1_got, d1_exp;

    int checks = 0;
    int errors = 0;

    mac_result_checker #(.NUM_VECTORS(1000), .FIFO_DEPTH(8), .TOL(0)) u_d0 (
        .clk(clk), .RST(RST), .start(start),
        .exp_valid(exp_valid), .exp_mac(exp_mac),
        .res_valid(res_valid), .res_mac(res_mac),
        .busy(d0_busy), .done(d0_done),
        .pass_count(d0_pass), .fail_count(d0_fail),
        .first_fail_idx(d0_idx), .first_fail_got(d0_got), .first_fail_exp(d0_exp),
        .overflow(d0_ov), .underflow(d0_un)
    );

    mac_result_checker #(.NUM_VECTORS(1000), .FIFO_DEPTH(8), .TOL(1)) u_d1 (
        .clk(clk), .RST(RST), .start(start),
        .exp_valid(exp_valid), .exp_mac(exp_mac),
        .res_valid(res_valid), .res_mac(res_mac),
        .busy(d1_busy), .done(d1_done),
        .pass_count(d1_pass), .fail_count(d1_fail),
        .first_fail_idx(d1_idx), .first_fail_got(d1_got), .first_fail_exp(d1_exp),
        .overflow(d1_ov), .underflow(d1_un)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic ev, input logic [31:0] em, input logic rv, input logic [31:0] rm);
        exp_valid = ev;
        exp_mac   = em;
        res_valid = rv;
        res_mac   = rm;
        tick();
    endtask

    task automatic do_start(input logic ev, input logic rv);
        start     = 1'b1;
        exp_valid = ev;
        exp_mac   = 32'h0000_0999;
        res_valid = rv;
        res_mac   = 32'h0000_0999;
        tick();
        start     = 1'b0;
        exp_valid = 1'b0;
        res_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] c_exp [4];
        logic [31:0] c_got [4];
        logic [31:0] rv;

        RST = 1'b1; start = 1'b0;
        exp_valid = 1'b0; exp_mac = 32'h0; res_valid = 1'b0; res_mac = 32'h0;
        #2;
        chk("rst_busy", d0_busy, 1'b0);
        chk("rst_done", d0_done, 1'b0);
        chk("rst_pass", d0_pass, 16'h0000);
        chk("rst_fail", d0_fail, 16'h0000);
        chk("rst_idx",  d0_idx,  16'hFFFF);
        chk("rst_got",  d0_got,  32'h0);
        chk("rst_exp",  d0_exp,  32'h0);
        chk("rst_ov",   d0_ov,   1'b0);
        chk("rst_un",   d0_un,   1'b0);
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("idle_busy", d0_busy, 1'b0);

        // Full 1000-vector run, results trailing expected values by 3 cycles.
        do_start(1'b0, 1'b0);
        chk("a_busy", d0_busy, 1'b1);
        for (int c = 0; c < 1003; c++) begin
            cyc(c < 1000, 32'h3F80_0000 + 32'(c), c >= 3, 32'h3F80_0000 + 32'(c - 3));
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("a_pass",      d0_pass, 16'd1000);
        chk("a_done_late", d0_done, 1'b0);
        tick();
        chk("a_done",    d0_done, 1'b1);
        chk("a_busy0",   d0_busy, 1'b0);
        chk("a_fail",    d0_fail, 16'd0);
        chk("a_idx",     d0_idx,  16'hFFFF);
        chk("a_d1_pass", d1_pass, 16'd1000);
        chk("a_d1_done", d1_done, 1'b1);
        cyc(1'b1, 32'h1, 1'b1, 32'h2);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("done_ign_pass", d0_pass, 16'd1000);
        chk("done_ign_fail", d0_fail, 16'd0);
        chk("done_ign_un",   d0_un,   1'b0);

        // Index 5 off by one ulp, index 7 off by two.
        do_start(1'b0, 1'b0);
        chk("b_busy", d0_busy, 1'b1);
        chk("b_pass0", d0_pass, 16'd0);
        for (int c = 0; c < 9; c++) begin
            rv = (c - 1 == 5) ? 32'h3F80_0001 : ((c - 1 == 7) ? 32'h3F80_0002 : 32'h3F80_0000);
            cyc(c < 8, 32'h3F80_0000, c >= 1, rv);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("b_d0_pass", d0_pass, 16'd6);
        chk("b_d0_fail", d0_fail, 16'd2);
        chk("b_d0_idx",  d0_idx,  16'd5);
        chk("b_d0_got",  d0_got,  32'h3F80_0001);
        chk("b_d0_exp",  d0_exp,  32'h3F80_0000);
        chk("b_d1_pass", d1_pass, 16'd7);
        chk("b_d1_fail", d1_fail, 16'd1);
        chk("b_d1_idx",  d1_idx,  16'd7);
        chk("b_d1_got",  d1_got,  32'h3F80_0002);
        chk("b_d1_exp",  d1_exp,  32'h3F80_0000);

        // Exponent carry, sign mismatch, negative values, got below exp.
        c_got = '{32'h4000_0000, 32'hC000_0000, 32'hBF80_0001, 32'h3F7F_FFFF};
        c_exp = '{32'h3FFF_FFFF, 32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000};
        do_start(1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cyc(c < 4, (c < 4) ? c_exp[c] : 32'h0, c >= 1, (c >= 1) ? c_got[c - 1] : 32'h0);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("c_d0_pass", d0_pass, 16'd0);
        chk("c_d0_fail", d0_fail, 16'd4);
        chk("c_d0_idx",  d0_idx,  16'd0);
        chk("c_d0_got",  d0_got,  32'h4000_0000);
        chk("c_d0_exp",  d0_exp,  32'h3FFF_FFFF);
        chk("c_d1_pass", d1_pass, 16'd3);
        chk("c_d1_fail", d1_fail, 16'd1);
        chk("c_d1_idx",  d1_idx,  16'd1);
        chk("c_d1_got",  d1_got,  32'hC000_0000);

        // Nine pushes into an 8-deep FIFO, then drain.
        do_start(1'b0, 1'b0);
        for (int c = 0; c < 8; c++) cyc(1'b1, 32'h100 + 32'(c), 1'b0, 32'h0);
        chk("d_ov_full", d0_ov, 1'b0);
        cyc(1'b1, 32'h108, 1'b0, 32'h0);
        chk("d_ov",    d0_ov, 1'b1);
        chk("d_d1_ov", d1_ov, 1'b1);
        for (int c = 0; c < 8; c++) cyc(1'b0, 32'h0, 1'b1, 32'h100 + 32'(c));
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("d_pass", d0_pass, 16'd8);
        chk("d_fail", d0_fail, 16'd0);
        chk("d_un",   d0_un,   1'b0);

        // Push and pop together while full.
        do_start(1'b0, 1'b0);
        chk("d2_ov_clr", d0_ov, 1'b0);
        for (int c = 0; c < 8; c++) cyc(1'b1, 32'h100 + 32'(c), 1'b0, 32'h0);
        cyc(1'b1, 32'h200, 1'b1, 32'h100);
        chk("d2_ov", d0_ov, 1'b0);
        for (int c = 1; c < 8; c++) cyc(1'b0, 32'h0, 1'b1, 32'h100 + 32'(c));
        cyc(1'b0, 32'h0, 1'b1, 32'h200);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("d2_pass", d0_pass, 16'd9);
        chk("d2_fail", d0_fail, 16'd0);
        cyc(1'b0, 32'h0, 1'b1, 32'h200);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("un_set",  d0_un,   1'b1);
        chk("un_pass", d0_pass, 16'd9);
        chk("un_fail", d0_fail, 16'd0);

        // Valids in the start cycle are ignored; push+pop on empty does not bypass.
        do_start(1'b1, 1'b1);
        chk("e_un0", d0_un, 1'b0);
        cyc(1'b1, 32'h400, 1'b1, 32'h400);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("e_un",    d0_un,   1'b1);
        chk("e_d1_un", d1_un,   1'b1);
        chk("e_pass0", d0_pass, 16'd0);
        chk("e_fail0", d0_fail, 16'd0);
        cyc(1'b0, 32'h0, 1'b1, 32'h400);
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("e_pass1", d0_pass, 16'd1);

        // A compare still in flight when start arrives is not counted.
        do_start(1'b0, 1'b0);
        cyc(1'b1, 32'h500, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 32'h999);
        do_start(1'b0, 1'b0);
        tick(); tick();
        chk("f_drop_pass", d0_pass, 16'd0);
        chk("f_drop_fail", d0_fail, 16'd0);
        chk("f_drop_idx",  d0_idx,  16'hFFFF);

        // Asynchronous reset after 10 results, then a fresh run.
        do_start(1'b0, 1'b0);
        for (int c = 0; c < 11; c++) begin
            rv = (c - 1 == 3) ? 32'h0000_DEAD : 32'h600 + 32'(c - 1);
            cyc(c < 10, 32'h600 + 32'(c), c >= 1, rv);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0);
        chk("g_pass", d0_pass, 16'd9);
        chk("g_fail", d0_fail, 16'd1);
        chk("g_idx",  d0_idx,  16'd3);
        @(posedge clk);
        #3;
        RST = 1'b1;
        #1;
        chk("g_rst_busy", d0_busy, 1'b0);
        chk("g_rst_pass", d0_pass, 16'd0);
        chk("g_rst_fail", d0_fail, 16'd0);
        chk("g_rst_idx",  d0_idx,  16'hFFFF);
        chk("g_rst_got",  d0_got,  32'h0);
        chk("g_rst_exp",  d0_exp,  32'h0);
        chk("g_rst_d1_busy", d1_busy, 1'b0);
        #1;
        RST = 1'b0;
        tick();
        do_start(1'b0, 1'b0);
        cyc(1'b1, 32'h700, 1'b0, 32'h0);
        cyc(1'b1, 32'h701, 1'b1, 32'h700);
        cyc(1'b0, 32'h0,   1'b1, 32'h702);
        cyc(1'b0, 32'h0,   1'b0, 32'h0);
        chk("h_pass", d0_pass, 16'd1);
        chk("h_fail", d0_fail, 16'd1);
        chk("h_idx",  d0_idx,  16'd1);
        chk("h_got",  d0_got,  32'h702);
        chk("h_exp",  d0_exp,  32'h701);
        chk("h_busy", d0_busy, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
